// File: rtl/bsg_manycore_io_responder_if.sv
// Request/response channel between a manycore requester and the IO responder.
// The requester side uses the master modport; the responder uses slave.
interface bsg_manycore_io_responder_if #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7
);
  logic                        v_i;
  logic                        we_i;
  logic [addr_width_p-1:0]     addr_i;
  logic [data_width_p-1:0]     data_i;
  logic [data_width_p/8-1:0]   mask_i;
  logic [x_cord_width_p-1:0]   src_x_i;
  logic [y_cord_width_p-1:0]   src_y_i;
  logic                        yumi_o;

  logic                        v_o;
  logic                        ready_i;
  logic [data_width_p-1:0]     data_o;
  logic                        we_o;
  logic                        err_o;
  logic [x_cord_width_p-1:0]   dst_x_o;
  logic [y_cord_width_p-1:0]   dst_y_o;

  modport master (
    output v_i, we_i, addr_i, data_i, mask_i, src_x_i, src_y_i, ready_i,
    input  yumi_o, v_o, data_o, we_o, err_o, dst_x_o, dst_y_o
  );

  modport slave (
    input  v_i, we_i, addr_i, data_i, mask_i, src_x_i, src_y_i, ready_i,
    output yumi_o, v_o, data_o, we_o, err_o, dst_x_o, dst_y_o
  );
endinterface

// File: rtl/bsg_manycore_io_responder.sv
// Single-entry load/store responder with byte-masked backing store, finish mailbox
// and request counters. Define BSG_MANYCORE_IO_RESPONDER_BOUNDS_CHECK_EN to flag out-of-range addresses.
module bsg_manycore_io_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int els_p          = 256,
  parameter int finish_addr_p  = els_p - 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_manycore_io_responder_if.slave bus,
  output logic                    finish_o,
  output logic [data_width_p-1:0] finish_tag_o,
  output logic [31:0]             ld_count_o,
  output logic [31:0]             st_count_o
);

  localparam int lg_els_lp     = $clog2(els_p);
  localparam int mask_width_lp = data_width_p / 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                    state_r;
  logic [data_width_p-1:0]   mem [els_p];
  logic [lg_els_lp-1:0]      idx;
  logic                      oob;
  logic                      yumi;
  logic                      wr_en;
  logic                      is_finish;

  logic [data_width_p-1:0]   data_r;
  logic                      we_r;
  logic                      err_r;
  logic [x_cord_width_p-1:0] dst_x_r;
  logic [y_cord_width_p-1:0] dst_y_r;
  logic                      finish_r;
  logic [data_width_p-1:0]   finish_tag_r;
  logic [31:0]               ld_count_r;
  logic [31:0]               st_count_r;

  assign idx = bus.addr_i[lg_els_lp-1:0];

`ifdef BSG_MANYCORE_IO_RESPONDER_BOUNDS_CHECK_EN
  assign oob = bus.addr_i >= addr_width_p'(els_p);
`else
  assign oob = 1'b0;
`endif

  // A full register can still accept when the sink drains it in the same cycle.
  assign yumi      = reset_n_i & bus.v_i & ((state_r == EMPTY) | bus.ready_i);
  assign wr_en     = yumi & bus.we_i & ~oob;
  assign is_finish = bus.addr_i == addr_width_p'(finish_addr_p);

  // NOTE: the backing store has no reset branch; clearing a RAM array on reset
  // prevents it from mapping onto memory macros and is not needed here.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (bus.mask_i[b]) mem[idx][8*b +: 8] <= bus.data_i[8*b +: 8];
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= EMPTY;
      data_r       <= '0;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      dst_x_r      <= '0;
      dst_y_r      <= '0;
      finish_r     <= 1'b0;
      finish_tag_r <= '0;
      ld_count_r   <= '0;
      st_count_r   <= '0;
    end else begin
      if (yumi) begin
        state_r <= FULL;
        data_r  <= (bus.we_i | oob) ? '0 : mem[idx];
        we_r    <= bus.we_i;
        err_r   <= oob;
        dst_x_r <= bus.src_x_i;
        dst_y_r <= bus.src_y_i;
        if (bus.we_i) begin
          if (st_count_r != 32'hFFFF_FFFF) st_count_r <= st_count_r + 32'd1;
          if (is_finish) begin
            finish_r     <= 1'b1;
            finish_tag_r <= bus.data_i;
          end
        end else if (ld_count_r != 32'hFFFF_FFFF) begin
          ld_count_r <= ld_count_r + 32'd1;
        end
      end else if (bus.ready_i) begin
        state_r <= EMPTY;
      end
    end
  end

  assign bus.yumi_o  = yumi;
  assign bus.v_o     = (state_r == FULL);
  assign bus.data_o  = data_r;
  assign bus.we_o    = we_r;
  assign bus.err_o   = err_r;
  assign bus.dst_x_o = dst_x_r;
  assign bus.dst_y_o = dst_y_r;

  assign finish_o     = finish_r;
  assign finish_tag_o = finish_tag_r;
  assign ld_count_o   = ld_count_r;
  assign st_count_o   = st_count_r;

endmodule

// File: tb/tb_bsg_manycore_io_responder.sv
// Randomized bench for bsg_manycore_io_responder against a queue-and-array reference model,
// plus directed scenarios for masking, back-pressure, finish mailbox, reset and addressing.
module tb_bsg_manycore_io_responder;

  localparam int aw   = 28;
  localparam int dw   = 32;
  localparam int xw   = 7;
  localparam int yw   = 7;
  localparam int els  = 256;
  localparam int fin  = els - 1;

`ifdef BSG_MANYCORE_IO_RESPONDER_BOUNDS_CHECK_EN
  localparam bit bounds_chk = 1'b1;
`else
  localparam bit bounds_chk = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          finish;
  logic [dw-1:0] finish_tag;
  logic [31:0]   ld_count;
  logic [31:0]   st_count;

  always #5 clk = ~clk;

  bsg_manycore_io_responder_if #(
    .addr_width_p(aw), .data_width_p(dw), .x_cord_width_p(xw), .y_cord_width_p(yw)
  ) bus ();

  bsg_manycore_io_responder #(
    .addr_width_p(aw), .data_width_p(dw), .x_cord_width_p(xw), .y_cord_width_p(yw),
    .els_p(els), .finish_addr_p(fin)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus         (bus),
    .finish_o    (finish),
    .finish_tag_o(finish_tag),
    .ld_count_o  (ld_count),
    .st_count_o  (st_count)
  );

  typedef struct {
    logic [dw-1:0] data;
    logic          we;
    logic          err;
    logic [xw-1:0] x;
    logic [yw-1:0] y;
  } resp_t;

  resp_t         exp_q[$];
  logic [dw-1:0] model_mem [els];
  logic          m_finish;
  logic [dw-1:0] m_tag;
  int unsigned   m_ld;
  int unsigned   m_st;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("v_o", 64'(bus.v_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("data_o",  64'(bus.data_o),  64'(exp_q[0].data));
      check("we_o",    64'(bus.we_o),    64'(exp_q[0].we));
      check("err_o",   64'(bus.err_o),   64'(exp_q[0].err));
      check("dst_x_o", 64'(bus.dst_x_o), 64'(exp_q[0].x));
      check("dst_y_o", 64'(bus.dst_y_o), 64'(exp_q[0].y));
    end
    check("finish_o",     64'(finish),     64'(m_finish));
    check("finish_tag_o", 64'(finish_tag), 64'(m_tag));
    check("ld_count_o",   64'(ld_count),   64'(m_ld));
    check("st_count_o",   64'(st_count),   64'(m_st));
  endtask

  // One clock of traffic: drive at the falling edge, predict, then check after the next rise.
  task automatic step(input logic v, input logic we, input logic [aw-1:0] addr,
                      input logic [dw-1:0] data, input logic [3:0] mask, input logic rdy);
    logic  exp_yumi;
    resp_t r;
    resp_t dropped;
    int    idx;
    bus.v_i     = v;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.data_i  = data;
    bus.mask_i  = mask;
    bus.src_x_i = xw'($urandom);
    bus.src_y_i = yw'($urandom);
    bus.ready_i = rdy;
    #1;
    exp_yumi = v && (exp_q.size() == 0 || rdy);
    check("yumi_o", 64'(bus.yumi_o), 64'(exp_yumi));
    if (exp_q.size() != 0 && rdy) dropped = exp_q.pop_front();
    if (exp_yumi) begin
      idx   = int'(addr % els);
      r.we  = we;
      r.err = bounds_chk && (addr >= els);
      r.x   = bus.src_x_i;
      r.y   = bus.src_y_i;
      if (we) begin
        r.data = '0;
        if (!r.err) begin
          for (int b = 0; b < 4; b++) begin
            if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
          end
        end
        if (addr == fin) begin
          m_finish = 1'b1;
          m_tag    = data;
        end
        m_st++;
      end else begin
        r.data = r.err ? '0 : model_mem[idx];
        m_ld++;
      end
      exp_q.push_back(r);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset_n     = 1'b0;
    bus.v_i     = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.data_i  = '0;
    bus.mask_i  = '0;
    bus.src_x_i = '0;
    bus.src_y_i = '0;
    bus.ready_i = 1'b0;
    #1;
    check("yumi_in_reset", 64'(bus.yumi_o), 64'(0));
    repeat (cycles) @(negedge clk);
    exp_q.delete();
    m_finish = 1'b0;
    m_tag    = '0;
    m_ld     = 0;
    m_st     = 0;
    check("reset_err_o", 64'(bus.err_o), 64'(0));
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [dw-1:0] held;
    logic [aw-1:0] a;

    do_reset(2);

    for (int i = 0; i < els; i++) step(1'b1, 1'b1, aw'(i), $urandom, 4'hF, 1'b1);

    // Full store then an immediate load of the same word.
    step(1'b1, 1'b1, 28'd5, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step(1'b1, 1'b0, 28'd5, 32'h0, 4'h0, 1'b1);
    check("ld5_v",    64'(bus.v_o),    64'(1));
    check("ld5_data", 64'(bus.data_o), 64'(32'hDEAD_BEEF));
    check("ld5_we",   64'(bus.we_o),   64'(0));

    // Byte-masked store over an all-ones word.
    step(1'b1, 1'b1, 28'd7, 32'hFFFF_FFFF, 4'hF, 1'b1);
    step(1'b1, 1'b1, 28'd7, 32'h1122_3344, 4'b0101, 1'b1);
    step(1'b1, 1'b0, 28'd7, 32'h0, 4'h0, 1'b1);
    check("ld7_data", 64'(bus.data_o), 64'(32'hFF22_FF44));

    // Back-pressure: one response held for five cycles, then full throughput.
    step(1'b0, 1'b0, 28'd0, 32'h0, 4'h0, 1'b1);
    held = model_mem[10];
    step(1'b1, 1'b0, 28'd10, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, aw'($urandom_range(0, els - 1)), 32'h0, 4'h0, 1'b0);
      check("hold_data", 64'(bus.data_o), 64'(held));
      check("hold_v",    64'(bus.v_o),    64'(1));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, aw'($urandom_range(0, els - 1)), 32'h0, 4'h0, 1'b1);

    // Address just past the backing store.
    step(1'b0, 1'b0, 28'd0, 32'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0, aw'(els + 3), 32'h0, 4'h0, 1'b1);
    if (bounds_chk) begin
      check("oob_err",  64'(bus.err_o),  64'(1));
      check("oob_data", 64'(bus.data_o), 64'(0));
    end else begin
      check("wrap_err",  64'(bus.err_o),  64'(0));
      check("wrap_data", 64'(bus.data_o), 64'(model_mem[3]));
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) a = aw'($urandom_range(els, 2 * els - 1));
      else                           a = aw'($urandom_range(0, els - 1));
      step($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom),
           $urandom_range(0, 2) != 0);
    end

    // Finish mailbox takes the full word even with an empty mask, then reset clears it.
    step(1'b1, 1'b1, aw'(fin), 32'h0000_002A, 4'h0, 1'b1);
    check("finish_set", 64'(finish),     64'(1));
    check("finish_tag", 64'(finish_tag), 64'(32'h2A));
    step(1'b1, 1'b0, 28'd1, 32'h0, 4'h0, 1'b0);
    do_reset(1);
    check("rst_finish", 64'(finish),   64'(0));
    check("rst_ld_cnt", 64'(ld_count), 64'(0));
    check("rst_st_cnt", 64'(st_count), 64'(0));
    check("rst_v_o",    64'(bus.v_o),  64'(0));
    step(1'b1, 1'b0, 28'd5, 32'h0, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_io_responder.md
BSG_MANYCORE_IO_RESPONDER -- requirements
Module: bsg_manycore_io_responder

Interface
REQ-001 SHALL have parameter addr_width_p, default 28, word-address width of requests.
REQ-002 SHALL have parameter data_width_p, default 32, data width in bits.
REQ-003 SHALL have parameters x_cord_width_p and y_cord_width_p, default 7 each, source-coordinate widths.
REQ-004 SHALL have parameter els_p, default 256, backing-store depth in words (power of two).
REQ-005 SHALL have parameter finish_addr_p, default els_p-1, word address of the finish mailbox.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port reset_n_i, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have port v_i, input, 1, request valid.
REQ-009 SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port addr_i, input, addr_width_p, request word address.
REQ-011 SHALL have port data_i, input, data_width_p, store data.
REQ-012 SHALL have port mask_i, input, data_width_p/8, store byte mask.
REQ-013 SHALL have ports src_x_i and src_y_i, inputs, x_cord_width_p and y_cord_width_p, requester coordinates.
REQ-014 SHALL have port yumi_o, output, 1, request consumed this cycle.
REQ-015 SHALL have port v_o, output, 1, response valid.
REQ-016 SHALL have port ready_i, input, 1, response sink ready.
REQ-017 SHALL have ports data_o (data_width_p), we_o (1), err_o (1), dst_x_o and dst_y_o (coordinate widths), all outputs, response payload.
REQ-018 SHALL have ports finish_o (1) and finish_tag_o (data_width_p), outputs, finish mailbox state.
REQ-019 SHALL have ports ld_count_o and st_count_o, outputs, 32 bits each, accepted-request counters.

Function
REQ-020 SHALL hold one response register with a 2-state FSM: EMPTY (v_o=0) and FULL (v_o=1).
REQ-021 SHALL drive yumi_o = v_i & (EMPTY | ready_i), combinationally, so back-to-back requests sustain one per cycle.
REQ-022 SHALL set v_o in the cycle after acceptance (1-cycle latency); FULL->EMPTY only on ready_i with no new acceptance; FULL->FULL when ready_i and yumi_o coincide.
REQ-023 SHALL hold all response payload stable while v_o=1 and ready_i=0.
REQ-024 SHALL return memory word at addr_i on data_o for a load, with we_o=0.
REQ-025 SHALL write only bytes with mask_i set for a store; response has we_o=1 and data_o=0.
REQ-026 SHALL copy src_x_i/src_y_i to dst_x_o/dst_y_o of the matching response.
REQ-027 SHALL, for a store to finish_addr_p, also set finish_o=1 (sticky) and load finish_tag_o with data_i (full word, mask ignored); a later finish store overwrites finish_tag_o.
REQ-028 SHALL increment ld_count_o/st_count_o by one per accepted load/store, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL ensure a load accepted in the cycle after a store to the same address returns the stored data.

Reset
REQ-030 SHALL, while reset_n_i=0 at a clk_i edge, force FSM to EMPTY, v_o=0, finish_o=0, finish_tag_o=0, counters=0, err_o=0.
REQ-031 SHALL hold yumi_o=0 during reset; a response pending when reset asserts is discarded.
REQ-032 SHALL NOT reset memory contents.

Configuration
REQ-033 SHALL recognize macro BSG_MANYCORE_IO_RESPONDER_BOUNDS_CHECK_EN.
REQ-034 SHALL, with the macro defined, flag addr_i >= els_p: err_o=1, no memory write, data_o=0, counters still increment.
REQ-035 SHALL, without the macro, index memory with addr_i modulo els_p and tie err_o to 0.

Verification
REQ-036 SHALL cover: store 0xDEADBEEF mask 4'hF addr 5, then load addr 5 -> load response data_o=0xDEADBEEF, we_o=0, one cycle after acceptance.
REQ-037 SHALL cover: store 0x11223344 mask 4'b0101 over 0xFFFFFFFF at addr 7, load 7 -> 0xFF22FF44.
REQ-038 SHALL cover: ready_i=0 for 5 cycles with v_i=1 -> one response held stable, yumi_o=0 after first accept; ready_i=1 -> one-per-cycle throughput resumes.
REQ-039 SHALL cover: store 0x0000002A to finish_addr_p -> finish_o=1, finish_tag_o=0x2A next cycle; reset_n_i=0 one cycle -> finish_o=0, counters 0.
REQ-040 SHALL cover: load addr els_p+3 -> err_o=1, data_o=0 with macro; data of addr 3 and err_o=0 without.
